// File: rtl/eth_fcs_pkg.sv
// Shared constants and types for the receive-path FCS checker.
//   ETH_CRC_POLY / ETH_CRC_INIT : reflected CRC-32 polynomial and register seed
//   ETH_CRC_RESIDUE             : crc_out seen after a correct frame including its FCS
//   ETH_MIN_BYTES / MAX_BYTES   : default legal frame length bounds, FCS included
//   fcs_state_t                 : checker FSM state
//   bitrev32                    : bit-order reversal helper
package eth_fcs_pkg;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'h38FB_2284;

  localparam int unsigned ETH_MIN_BYTES = 64;
  localparam int unsigned ETH_MAX_BYTES = 1522;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } fcs_state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_dw.sv
// Reflected CRC-32 register consuming DW bits per clock, bit 0 first.
//   clk, rst : clock, synchronous active-low reset (register -> ETH_CRC_INIT)
//   init     : restart from ETH_CRC_INIT; combined with en, the beat is folded
//              into the seed rather than the current register
//   en       : fold d into the CRC this cycle
//   d        : data beat, d[0] is earliest on the wire
//   crc_out  : bit-reversed complement of the register
module crc32_dw
  import eth_fcs_pkg::*;
#(
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [31:0]   crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_next;

  always_comb begin
    crc_next = init ? ETH_CRC_INIT : crc_q;
    if (en) begin
      for (int unsigned i = 0; i < DW; i++) begin
        crc_next = {1'b0, crc_next[31:1]} ^
                   ((crc_next[0] ^ d[i]) ? ETH_CRC_POLY : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= ETH_CRC_INIT;
    end else begin
      crc_q <= crc_next;
    end
  end

  assign crc_out = bitrev32(~crc_q);

endmodule

// File: rtl/eth_fcs_checker.sv
// Receive-path Ethernet FCS / length / alignment checker.
//   clk, rst   : clock, synchronous active-low reset
//   axiid      : DW-bit beat, bit 0 first on the wire
//   axiiv      : beat valid, high for the whole frame
//   done       : one-cycle verdict strobe, one cycle after the first low-valid cycle
//   kill       : frame bad (CRC, length or alignment); held until next frame start
//   len_err    : length/alignment error; held until next frame start
//   frame_len  : byte count of last frame, saturating at MAX_BYTES+1
//   busy       : frame in progress (RUN or DROP)
//   good_cnt   : saturating count of frames with kill=0
//   bad_cnt    : saturating count of frames with kill=1
module eth_fcs_checker
  import eth_fcs_pkg::*;
#(
  parameter int unsigned DW        = 2,
  parameter int unsigned MIN_BYTES = ETH_MIN_BYTES,
  parameter int unsigned MAX_BYTES = ETH_MAX_BYTES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    axiid,
  input  logic             axiiv,
  output logic             done,
  output logic             kill,
  output logic             len_err,
  output logic [10:0]      frame_len,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int unsigned BPB       = 8 / DW;
  localparam int unsigned BPB_LOG   = $clog2(BPB);
  localparam int unsigned MAX_BEATS = (MAX_BYTES + 1) * BPB;
  localparam int unsigned BW        = $clog2(MAX_BEATS + 1);

  fcs_state_t    state;
  logic [BW-1:0] beats;
  logic [BW-1:0] bytes;
  logic          partial;
  logic          len_err_c;
  logic          kill_c;
  logic          crc_init;
  logic          crc_en;
  logic [31:0]   crc_out;

  // The register is seeded whenever no frame is accumulating, including the
  // EOF cycle, so a frame starting right after a single idle cycle is clean.
  assign crc_init = (state != RUN) || !axiiv;
  assign crc_en   = axiiv && (state != DROP);

  crc32_dw #(.DW(DW)) u_crc (
    .clk     (clk),
    .rst     (rst),
    .init    (crc_init),
    .en      (crc_en),
    .d       (axiid),
    .crc_out (crc_out)
  );

  // BPB is a power of two, so division and modulo reduce to shift and mask.
  assign bytes     = beats >> BPB_LOG;
  assign partial   = (beats & BW'(BPB - 1)) != '0;
  assign len_err_c = (bytes < BW'(MIN_BYTES)) || (bytes > BW'(MAX_BYTES)) || partial;
  assign kill_c    = len_err_c || (crc_out != ETH_CRC_RESIDUE);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // A frame already streaming at reset release is discarded whole.
      state     <= axiiv ? DROP : IDLE;
      beats     <= '0;
      done      <= 1'b0;
      kill      <= 1'b0;
      len_err   <= 1'b0;
      frame_len <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (axiiv) begin
            state   <= RUN;
            beats   <= BW'(1);
            kill    <= 1'b0;
            len_err <= 1'b0;
          end
        end
        RUN: begin
          if (axiiv) begin
            // Saturating at MAX_BYTES+1 bytes keeps oversize frames flagged
            // without truncating them.
            if (beats != BW'(MAX_BEATS)) begin
              beats <= beats + BW'(1);
            end
          end else begin
            state     <= IDLE;
            done      <= 1'b1;
            len_err   <= len_err_c;
            kill      <= kill_c;
            frame_len <= 11'(bytes);
            if (kill_c) begin
              if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
            end else begin
              if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
            end
          end
        end
        DROP: begin
          if (!axiiv) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
